// File: rtl/interleaver_if.sv
// Serial bit stream bundle between the convolutional encoder, the interleaver and the mapper.
// The master drives the coded input and rate strobes; the slave returns interleaved bits.
interface interleaver_if;
    logic       iEN;
    logic       iRateEN;
    logic [3:0] iRate;
    logic       iData;
    logic       oData;
    logic       oValid;

    modport master (
        output iEN,
        output iRateEN,
        output iRate,
        output iData,
        input  oData,
        input  oValid
    );

    modport slave (
        input  iEN,
        input  iRateEN,
        input  iRate,
        input  iData,
        output oData,
        output oValid
    );
endinterface

// File: rtl/interleaver.sv
// 802.11a TX block interleaver: serial coded bits in, permuted bits out one symbol later.
// Ping-pong bit banks; write address j is built from k slices and small mod-3 counters, no dividers.
module interleaver #(
    parameter int MAX_NCBPS = 288,
    parameter int ADDR_W    = 9
) (
    input  logic         iClk,
    input  logic         iRst,
    interleaver_if.slave bus
);

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_QAM16 = 2'd2,
        MOD_QAM64 = 2'd3
    } mod_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_BUSY = 1'b1
    } rd_state_t;

    function automatic mod_t rate_mod(input logic [3:0] r);
        mod_t m;
        case (r[3:2])
            2'b11:   m = MOD_BPSK;
            2'b01:   m = MOD_QPSK;
            2'b10:   m = MOD_QAM16;
            default: m = MOD_QAM64;
        endcase
        return m;
    endfunction

    function automatic logic [ADDR_W-1:0] mod_ncbps(input mod_t m);
        logic [ADDR_W-1:0] n;
        case (m)
            MOD_BPSK:  n = ADDR_W'(48);
            MOD_QPSK:  n = ADDR_W'(96);
            MOD_QAM16: n = ADDR_W'(192);
            default:   n = ADDR_W'(288);
        endcase
        return n;
    endfunction

    function automatic logic [1:0] mod3_4b(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: r = 2'd0;
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       r = 2'd1;
            default:                              r = 2'd2;
        endcase
        return r;
    endfunction

    logic [3:0]           rate_r;
    logic [ADDR_W-1:0]    k_r;
    logic [1:0]           kd3_r;
    logic                 wr_bank_r;
    logic [1:0]           full_r;
    mod_t                 bank_mod_r [0:1];
    logic                 rd_bank_r;
    logic [ADDR_W-1:0]    rd_addr_r;
    rd_state_t            rd_state_r;
    logic                 odata_r;
    logic                 ovalid_r;
    logic [MAX_NCBPS-1:0] mem0_r;
    logic [MAX_NCBPS-1:0] mem1_r;

    mod_t                 wr_mod_s;
    logic [ADDR_W-1:0]    wr_ncbps_s;
    logic                 wr_last_s;
    logic [3:0]           km_s;
    logic [ADDR_W-5:0]    kd_s;
    logic [1:0]           km3_s;
    logic [1:0]           t_s;
    logic [ADDR_W-1:0]    i_s;
    logic [ADDR_W-1:0]    j_s;
    logic [ADDR_W-1:0]    rd_ncbps_s;
    logic [ADDR_W-1:0]    rd_sel_addr_s;
    logic                 rd_bit_s;

    assign wr_mod_s   = rate_mod(rate_r);
    assign wr_ncbps_s = mod_ncbps(wr_mod_s);
    assign wr_last_s  = bus.iEN && (k_r == (wr_ncbps_s - ADDR_W'(1)));
    assign km_s       = k_r[3:0];
    assign kd_s       = k_r[ADDR_W-1:4];
    assign km3_s      = mod3_4b(km_s);

    // First permutation: i = (NCBPS/16)*(k mod 16) + k div 16, column count is a constant per rate
    always_comb begin
        i_s = ADDR_W'(kd_s);
        case (wr_mod_s)
            MOD_BPSK:  i_s = ADDR_W'(km_s) * ADDR_W'(3)  + ADDR_W'(kd_s);
            MOD_QPSK:  i_s = ADDR_W'(km_s) * ADDR_W'(6)  + ADDR_W'(kd_s);
            MOD_QAM16: i_s = ADDR_W'(km_s) * ADDR_W'(12) + ADDR_W'(kd_s);
            default:   i_s = ADDR_W'(km_s) * ADDR_W'(18) + ADDR_W'(kd_s);
        endcase
    end

    // Second permutation: since NCBPS/16 is a multiple of s, i mod s = kd mod s and floor(i*16/NCBPS) = k mod 16
    always_comb begin
        t_s = 2'd0;
        if (kd3_r >= km3_s) begin
            t_s = kd3_r - km3_s;
        end else begin
            t_s = kd3_r + 2'd3 - km3_s;
        end
        j_s = i_s;
        case (wr_mod_s)
            MOD_QAM16: j_s = {i_s[ADDR_W-1:1], i_s[0] ^ km_s[0]};
            MOD_QAM64: j_s = i_s - ADDR_W'(kd3_r) + ADDR_W'(t_s);
            default:   j_s = i_s;
        endcase
    end

    assign rd_ncbps_s    = mod_ncbps(bank_mod_r[rd_bank_r]);
    assign rd_sel_addr_s = (rd_state_r == RD_BUSY) ? rd_addr_r : ADDR_W'(0);
    assign rd_bit_s      = rd_bank_r ? mem1_r[rd_sel_addr_s] : mem0_r[rd_sel_addr_s];

    // Bit storage for both banks, written at the permuted address
    always_ff @(posedge iClk) begin
        if (bus.iEN) begin
            if (wr_bank_r) begin
                mem1_r[j_s] <= bus.iData;
            end else begin
                mem0_r[j_s] <= bus.iData;
            end
        end
    end

    // Rate register, write counters, bank flags and the read-out FSM
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rate_r        <= 4'b1101;
            k_r           <= '0;
            kd3_r         <= 2'd0;
            wr_bank_r     <= 1'b0;
            full_r        <= 2'b00;
            bank_mod_r[0] <= MOD_BPSK;
            bank_mod_r[1] <= MOD_BPSK;
            rd_bank_r     <= 1'b0;
            rd_addr_r     <= '0;
            rd_state_r    <= RD_IDLE;
            odata_r       <= 1'b0;
            ovalid_r      <= 1'b0;
        end else begin
            if (bus.iRateEN && (k_r == ADDR_W'(0)) && bus.iRate[0]) begin
                rate_r <= bus.iRate;
            end

            if (bus.iEN) begin
                if (wr_last_s) begin
                    k_r                   <= '0;
                    kd3_r                 <= 2'd0;
                    full_r[wr_bank_r]     <= 1'b1;
                    bank_mod_r[wr_bank_r] <= wr_mod_s;
                    wr_bank_r             <= ~wr_bank_r;
                end else begin
                    k_r <= k_r + ADDR_W'(1);
                    if (km_s == 4'hF) begin
                        kd3_r <= (kd3_r == 2'd2) ? 2'd0 : kd3_r + 2'd1;
                    end
                end
            end

            case (rd_state_r)
                RD_IDLE: begin
                    if (full_r[rd_bank_r]) begin
                        odata_r    <= rd_bit_s;
                        ovalid_r   <= 1'b1;
                        rd_addr_r  <= ADDR_W'(1);
                        rd_state_r <= RD_BUSY;
                    end else begin
                        odata_r  <= 1'b0;
                        ovalid_r <= 1'b0;
                    end
                end
                RD_BUSY: begin
                    odata_r  <= rd_bit_s;
                    ovalid_r <= 1'b1;
                    if (rd_addr_r == (rd_ncbps_s - ADDR_W'(1))) begin
                        full_r[rd_bank_r] <= 1'b0;
                        rd_bank_r         <= ~rd_bank_r;
                        rd_addr_r         <= '0;
                        rd_state_r        <= RD_IDLE;
                    end else begin
                        rd_addr_r <= rd_addr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    odata_r    <= 1'b0;
                    ovalid_r   <= 1'b0;
                    rd_addr_r  <= '0;
                    rd_state_r <= RD_IDLE;
                end
            endcase
        end
    end

    assign bus.oData  = odata_r;
    assign bus.oValid = ovalid_r;

endmodule

// File: tb/tb_interleaver.sv
// Scoreboard bench for the 802.11a interleaver: stimulus pushes expected output bits,
// a negedge monitor pops and compares them whenever oValid is high.
module tb_interleaver;

    logic iClk;
    logic iRst;
    interleaver_if bus ();

    interleaver #(.MAX_NCBPS(288), .ADDR_W(9)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int   total;
    int   bad;
    logic exp_q[$];
    bit   mon_en;
    int   valid_cnt;
    int   rise_cnt;
    logic prev_valid;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Golden index model written directly from the standard's two-step formula
    function automatic int perm(input int k, input int ncbps, input int nbpsc);
        int s;
        int i;
        s = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
        i = (ncbps / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
    endfunction

    initial begin
        logic e;
        prev_valid = 1'b0;
        forever begin
            @(negedge iClk);
            if (mon_en) begin
                if (bus.oValid) begin
                    valid_cnt++;
                    if (!prev_valid) rise_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_bit", int'(bus.oData), int'(e));
                    end
                end else begin
                    check("idle_data_zero", int'(bus.oData), 0);
                end
            end
            prev_valid = bus.oValid;
        end
    end

    task automatic set_rate(input logic [3:0] code);
        bus.iRateEN = 1'b1;
        bus.iRate   = code;
        @(posedge iClk);
        #1;
        bus.iRateEN = 1'b0;
    endtask

    task automatic run_sym(input int n, input logic [287:0] in_v, input logic [287:0] exp_v,
                           input bit do_push, input int rate_k, input logic [3:0] rate_code);
        if (do_push) begin
            for (int p = 0; p < n; p++) exp_q.push_back(exp_v[p]);
        end
        for (int k = 0; k < n; k++) begin
            bus.iEN     = 1'b1;
            bus.iData   = in_v[k];
            bus.iRateEN = (k == rate_k);
            bus.iRate   = rate_code;
            @(posedge iClk);
            #1;
        end
        bus.iEN     = 1'b0;
        bus.iData   = 1'b0;
        bus.iRateEN = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.oValid) && c < 1000) begin
            @(posedge iClk);
            #1;
            c++;
        end
        check(name, exp_q.size(), 0);
        check({name, "_idle"}, int'(bus.oValid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [287:0] iv;
        logic [287:0] ev;
        int v0;
        int r0;

        total = 0;
        bad   = 0;
        mon_en = 1'b0;
        valid_cnt = 0;
        rise_cnt  = 0;
        iRst = 1'b1;
        bus.iEN = 1'b0;
        bus.iRateEN = 1'b0;
        bus.iRate = 4'b0000;
        bus.iData = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_ovalid", int'(bus.oValid), 0);
        check("reset_odata", int'(bus.oData), 0);
        iRst = 1'b0;
        mon_en = 1'b1;

        // 6 Mbps default: k=1 -> 3, then k=47 -> 47
        iv = '0; iv[1] = 1'b1; ev = '0; ev[3] = 1'b1;
        v0 = valid_cnt;
        run_sym(48, iv, ev, 1'b1, -1, 4'b0000);
        wait_drain("bpsk_k1");
        check("bpsk_valid_cycles", valid_cnt - v0, 48);
        iv = '0; iv[47] = 1'b1; ev = '0; ev[47] = 1'b1;
        run_sym(48, iv, ev, 1'b1, -1, 4'b0000);
        wait_drain("bpsk_k47");

        // QPSK: k=17 -> 7
        set_rate(4'b0101);
        iv = '0; iv[17] = 1'b1; ev = '0; ev[7] = 1'b1;
        run_sym(96, iv, ev, 1'b1, -1, 4'b0000);
        wait_drain("qpsk_k17");

        // 16-QAM: k=17 -> 12
        set_rate(4'b1001);
        iv = '0; iv[17] = 1'b1; ev = '0; ev[12] = 1'b1;
        run_sym(192, iv, ev, 1'b1, -1, 4'b0000);
        wait_drain("qam16_k17");

        // 54 Mbps: k=1 -> 20, k=33 -> 19, plus output latency
        set_rate(4'b0011);
        iv = '0; iv[1] = 1'b1; iv[33] = 1'b1; ev = '0; ev[20] = 1'b1; ev[19] = 1'b1;
        run_sym(288, iv, ev, 1'b1, -1, 4'b0000);
        check("latency_before", int'(bus.oValid), 0);
        @(posedge iClk);
        #1;
        check("latency_after", int'(bus.oValid), 1);
        wait_drain("qam64_k1_k33");

        // 36 Mbps, two random symbols back to back
        set_rate(4'b1011);
        v0 = valid_cnt;
        r0 = rise_cnt;
        for (int s = 0; s < 2; s++) begin
            iv = '0;
            ev = '0;
            for (int k = 0; k < 192; k++) iv[k] = 1'($urandom_range(1, 0));
            for (int k = 0; k < 192; k++) ev[perm(k, 192, 4)] = iv[k];
            run_sym(192, iv, ev, 1'b1, -1, 4'b0000);
        end
        wait_drain("qam16_random");
        check("cont_valid_cycles", valid_cnt - v0, 384);
        check("cont_valid_runs", rise_cnt - r0, 1);

        // Rate strobe mid-symbol and an invalid code at a boundary are both ignored
        set_rate(4'b1101);
        iv = '0; iv[1] = 1'b1; ev = '0; ev[3] = 1'b1;
        run_sym(48, iv, ev, 1'b1, 10, 4'b0011);
        wait_drain("rate_mid_ignored");
        set_rate(4'b0100);
        iv = '0; iv[47] = 1'b1; ev = '0; ev[47] = 1'b1;
        run_sym(48, iv, ev, 1'b1, -1, 4'b0000);
        wait_drain("rate_invalid_ignored");

        // Reset during read-out of one symbol and at k=100 of the next
        set_rate(4'b0011);
        mon_en = 1'b0;
        iv = '1;
        run_sym(288, iv, iv, 1'b0, -1, 4'b0000);
        run_sym(100, iv, iv, 1'b0, -1, 4'b0000);
        check("pre_reset_valid", int'(bus.oValid), 1);
        #2;
        iRst = 1'b1;
        #1;
        check("reset_mid_ovalid", int'(bus.oValid), 0);
        check("reset_mid_odata", int'(bus.oData), 0);
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        iv = '0; iv[1] = 1'b1; ev = '0; ev[3] = 1'b1;
        run_sym(48, iv, ev, 1'b1, -1, 4'b0000);
        wait_drain("post_reset_bpsk");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interleaver.md
Name: interleaver

Overview:
- TX-side 802.11a block interleaver, the inverse of the RX deinterleaver.
- Takes the serial coded (punctured) bit stream from the convolutional encoder, one bit per clock.
- Applies the two-step 802.11a per-symbol permutation for the selected rate.
- Emits the interleaved bits serially to the mapper.
- Double-buffered (ping-pong), so continuous input produces continuous output delayed by one OFDM symbol.

Parameters:
- MAX_NCBPS, 288, coded bits per symbol at the highest modulation (64-QAM); sets the depth of each buffer bank.
- ADDR_W, 9, bit-address width; ceil(log2(MAX_NCBPS)).

Ports:
- iClk  in  1  system clock; all state updates on its rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iEN  in  1  input strobe; iData is captured on each rising edge where iEN=1.
- iRateEN  in  1  one-cycle strobe; loads iRate.
- iRate  in  4  802.11a RATE field code.
- iData  in  1  serial coded bit.
- oData  out  1  serial interleaved bit, registered.
- oValid  out  1  high while oData holds a valid bit, registered.

Behaviour:
- Reset (iRst=1, asynchronous):
  - oData=0, oValid=0.
  - Rate register = 4'b1101 (6 Mbps).
  - Write and read counters = 0; both banks marked empty; write bank = 0.
- Rate decode (NCBPS / NBPSC):
  - 1101, 1111 -> 48 / 1
  - 0101, 0111 -> 96 / 2
  - 1001, 1011 -> 192 / 4
  - 0001, 0011 -> 288 / 6
  - Any other code (iRate[0]=0) on an iRateEN strobe is ignored; the previous rate is kept.
- Rate loading: iRateEN is accepted only when the write counter is 0 (symbol boundary). Otherwise it is ignored. The rate in force when a symbol's first bit is written applies to that whole symbol, including its read-out.
- Permutation, for input index k (0..NCBPS-1), with s = max(NBPSC/2, 1):
  - i = (NCBPS/16)*(k mod 16) + floor(k/16)
  - j = s*floor(i/s) + (i + NCBPS - floor(16*i/NCBPS)) mod s
  - Output bit position j equals input bit k.
  - Implementation: bit k is written to the write bank at address j; the read side reads addresses 0..NCBPS-1 in order.
  - j must be produced without generic dividers: incremental counters (k mod 16 / k div 16, i div s, i div (NCBPS/16)) or constant-multiply tables only.
- Write side:
  - Each cycle with iEN=1: store iData, increment k.
  - At k=NCBPS-1: mark the bank full, toggle the write bank, reset k to 0.
  - iEN=0 pauses writing; a partial symbol is held indefinitely.
- Read side:
  - Starts on the cycle after the write bank fills.
  - Reads one bit per clock, independent of iEN, for NCBPS cycles, then marks the bank empty.
  - Latency: the bit at j=0 appears on oData with oValid=1 on the first rising edge after the edge that captured input bit NCBPS-1.
- Back-to-back symbols: if the next symbol completes on the same edge the current read-out finishes, reading continues with no gap. Input at ≤1 bit/clock cannot overflow the buffers.
- Gaps: oValid drops to 0 between read-outs when the next symbol is incomplete. oData=0 whenever oValid=0.
- Reset mid-operation: partial and pending symbols are discarded; outputs return to reset values immediately.

Test Plan:
- 6 Mbps, one 48-bit symbol with only k=1 set -> 48 oValid cycles; the single 1 appears at output position 3. Check k=47 -> position 47.
- 16-QAM (1001), one 192-bit symbol with only k=17 set -> the single 1 appears at output position 12; all other bits 0.
- 54 Mbps (0011), one 288-bit symbol with only k=1 set -> the single 1 appears at position 20. Check latency: oValid rises exactly 1 clock after the last input edge.
- 36 Mbps, 384 random bits (2 symbols) with continuous iEN -> oValid high for 384 consecutive cycles; output matches the MATLAB golden file bit-exactly.
- iRateEN=1 with 0011 issued mid-symbol at 6 Mbps, and an invalid code 0100 at a boundary -> both ignored; NCBPS stays 48.
- iRst pulsed at k=100 of a 288-bit symbol -> oValid=0 immediately; then a fresh 6 Mbps symbol interleaves correctly with no residue.
